read_issue_ctrl: RTL and testbench

Issue controller in front of the register-read stage. It tracks in-flight register writes with per-register pending counters and holds a decoded instruction back while any of its source registers still awaits writeback. It serialises control-flow instructions (PC set/add, including compare-on-reg_b branches) by draining all pending writes and then blocking issue until fetch reports the PC redirect complete. It sits between decode and the read stage; its `dec_ready` is the read stage's accept strobe.

---
 rtl/read_issue_pkg.sv | 14 +
 rtl/read_pend_cnt.sv | 37 +++
 rtl/read_issue_ctrl.sv | 94 +++++++++
 tb/tb_read_issue_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/read_issue_pkg.sv
// Shared types and defaults for the read-stage issue controller.
package read_issue_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        WAIT_PC = 2'd2
    } issue_state_t;

    localparam int NREGS_DEF  = 16;
    localparam int REG_IDX_W  = $clog2(NREGS_DEF);
    localparam int PEND_CNT_W = 2;

endpackage

// File: rtl/read_pend_cnt.sv
// One per-register pending-write counter; a writeback against an empty count
// leaves it at zero and raises err for that cycle.
module read_pend_cnt
    import read_issue_pkg::*;
#(
    parameter int CNT_W = PEND_CNT_W
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             max,
    output logic             one,
    output logic             err
);

    logic dec_eff;

    assign zero    = (cnt == '0);
    assign max     = &cnt;
    assign one     = (cnt == CNT_W'(1));
    assign dec_eff = dec & ~zero;
    assign err     = dec & zero;

    // Simultaneous issue and retire cancel out; the Full stall keeps inc off at max.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst)
            cnt <= '0;
        else if (inc && !dec_eff)
            cnt <= cnt + 1'b1;
        else if (!inc && dec_eff)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/read_issue_ctrl.sv
// Issue controller ahead of register read: scoreboards in-flight writes and
// serialises control flow. Define READ_ISSUE_WB_BYPASS_EN for same-cycle writeback bypass.
module read_issue_ctrl
    import read_issue_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int CNT_W = PEND_CNT_W
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic                     read_a,
    input  logic                     read_b,
    input  logic [$clog2(NREGS)-1:0] arg_a,
    input  logic [$clog2(NREGS)-1:0] arg_b,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_reg,
    input  logic                     dec_serial,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_reg,
    input  logic                     pc_done,
    input  logic                     flush,
    output logic                     busy,
    output logic [1:0]               state_o,
    output logic                     wb_err
);

    localparam int IW = $clog2(NREGS);

`ifdef READ_ISSUE_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    issue_state_t state;

    logic [NREGS-1:0]            inc_v, dec_v, zero_v, max_v, one_v, err_v;
    logic [NREGS-1:0][CNT_W-1:0] cnt_v;
    logic                        haz_a, haz_b, full, drained;

    for (genvar r = 0; r < NREGS; r++) begin : g_pend
        assign inc_v[r] = dec_ready & wr_en & (wr_reg == IW'(r));
        assign dec_v[r] = wb_en & (wb_reg == IW'(r));

        read_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .cpu_clk (cpu_clk),
            .cpu_rst (cpu_rst),
            .inc     (inc_v[r]),
            .dec     (dec_v[r]),
            .cnt     (cnt_v[r]),
            .zero    (zero_v[r]),
            .max     (max_v[r]),
            .one     (one_v[r]),
            .err     (err_v[r])
        );
    end

    // With bypass, a last pending write retiring this cycle no longer blocks.
    assign haz_a   = read_a & ~zero_v[arg_a] & ~(WB_BYPASS & one_v[arg_a] & dec_v[arg_a]);
    assign haz_b   = read_b & ~zero_v[arg_b] & ~(WB_BYPASS & one_v[arg_b] & dec_v[arg_b]);
    assign full    = wr_en & max_v[wr_reg];
    assign drained = &(zero_v | ({NREGS{WB_BYPASS}} & one_v & dec_v));
    assign busy    = ~&zero_v;
    assign state_o = state;

    assign dec_ready = (state == RUN) & dec_valid & ~haz_a & ~haz_b & ~full
                     & ~(dec_serial & busy);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state  <= RUN;
            wb_err <= 1'b0;
        end else begin
            if (|err_v)
                wb_err <= 1'b1;
            case (state)
                RUN: begin
                    if (dec_valid && dec_serial) begin
                        if (busy)
                            state <= DRAIN;
                        else if (dec_ready)
                            state <= WAIT_PC;
                    end
                end
                DRAIN:   if (flush || drained) state <= RUN;
                WAIT_PC: if (flush || pc_done) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_read_issue_ctrl.sv
// Directed table-driven bench for read_issue_ctrl plus an async-reset sequence.
module tb_read_issue_ctrl;
    import read_issue_pkg::*;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst = 1'b0;
    logic       dec_valid, dec_ready, read_a, read_b, wr_en, dec_serial;
    logic       wb_en, pc_done, flush, busy, wb_err;
    logic [3:0] arg_a, arg_b, wr_reg, wb_reg;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;

    read_issue_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .read_a(read_a), .read_b(read_b), .arg_a(arg_a), .arg_b(arg_b),
        .wr_en(wr_en), .wr_reg(wr_reg), .dec_serial(dec_serial), .wb_en(wb_en),
        .wb_reg(wb_reg), .pc_done(pc_done), .flush(flush), .busy(busy),
        .state_o(state_o), .wb_err(wb_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic       dv, ra;
        logic [3:0] aa;
        logic       we;
        logic [3:0] wr;
        logic       ser, wbe;
        logic [3:0] wbr;
        logic       pcd, fl;
        logic       e_rdy, e_busy;
        logic [1:0] e_st;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic dv, input logic ra, input logic [3:0] aa,
                       input logic we, input logic [3:0] wr, input logic ser,
                       input logic wbe, input logic [3:0] wbr, input logic pcd,
                       input logic fl, input logic e_rdy, input logic e_busy,
                       input logic [1:0] e_st, input logic e_err);
        vec_t v;
        v.dv = dv; v.ra = ra; v.aa = aa; v.we = we; v.wr = wr; v.ser = ser;
        v.wbe = wbe; v.wbr = wbr; v.pcd = pcd; v.fl = fl;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_st = e_st; v.e_err = e_err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic idle_inputs();
        dec_valid = 0; read_a = 0; read_b = 0; arg_a = 0; arg_b = 0;
        wr_en = 0; wr_reg = 0; dec_serial = 0; wb_en = 0; wb_reg = 0;
        pc_done = 0; flush = 0;
    endtask

    localparam logic [1:0] R = 2'd0, D = 2'd1, W = 2'd2;

    initial begin
        idle_inputs();
        // dv ra aa we wr ser wbe wbr pcd fl | rdy busy st err
        // RAW hazard on r3
        add(1,0,0, 1,3, 0, 0,0, 0,0,  1,1,R,0);
        add(1,1,3, 0,0, 0, 0,0, 0,0,  0,1,R,0);
`ifdef READ_ISSUE_WB_BYPASS_EN
        add(1,1,3, 0,0, 0, 1,3, 0,0,  1,0,R,0);
`else
        add(1,1,3, 0,0, 0, 1,3, 0,0,  0,0,R,0);
`endif
        add(1,1,3, 0,0, 0, 0,0, 0,0,  1,0,R,0);
        // Saturation on r5
        add(1,0,0, 1,5, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 1,5, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 1,5, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 1,5, 0, 0,0, 0,0,  0,1,R,0);
        add(1,0,0, 1,5, 0, 1,5, 0,0,  0,1,R,0);
        add(1,0,0, 1,5, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 1,5, 0, 0,0, 0,0,  0,1,R,0);
        add(0,0,0, 0,0, 0, 1,5, 0,0,  0,1,R,0);
        add(0,0,0, 0,0, 0, 1,5, 0,0,  0,1,R,0);
        add(0,0,0, 0,0, 0, 1,5, 0,0,  0,0,R,0);
        // Same-cycle issue and retire on r7
        add(1,0,0, 1,7, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 1,7, 0, 1,7, 0,0,  1,1,R,0);
        add(0,0,0, 0,0, 0, 1,7, 0,0,  0,0,R,0);
        // Serial instruction behind pending r2; pc_done ignored in DRAIN
        add(1,0,0, 1,2, 0, 0,0, 0,0,  1,1,R,0);
        add(1,0,0, 0,0, 1, 0,0, 0,0,  0,1,D,0);
        add(1,0,0, 0,0, 1, 0,0, 1,0,  0,1,D,0);
`ifdef READ_ISSUE_WB_BYPASS_EN
        add(1,0,0, 0,0, 1, 1,2, 0,0,  0,0,R,0);
        add(1,0,0, 0,0, 1, 0,0, 0,0,  1,0,W,0);
        add(0,0,0, 0,0, 0, 0,0, 0,0,  0,0,W,0);
`else
        add(1,0,0, 0,0, 1, 1,2, 0,0,  0,0,D,0);
        add(1,0,0, 0,0, 1, 0,0, 0,0,  0,0,R,0);
        add(1,0,0, 0,0, 1, 0,0, 0,0,  1,0,W,0);
`endif
        add(1,1,2, 0,0, 0, 0,0, 0,0,  0,0,W,0);
        add(1,1,2, 0,0, 0, 0,0, 0,0,  0,0,W,0);
        add(1,1,2, 0,0, 0, 0,0, 0,0,  0,0,W,0);
        add(1,1,2, 0,0, 0, 0,0, 1,0,  0,0,R,0);
        add(1,1,2, 0,0, 0, 0,0, 0,0,  1,0,R,0);
        // Sticky wb_err, flush out of WAIT_PC and DRAIN keeps counters
        add(0,0,0, 0,0, 0, 1,9, 0,0,  0,0,R,1);
        add(0,0,0, 0,0, 0, 0,0, 0,0,  0,0,R,1);
        add(1,0,0, 1,4, 1, 0,0, 0,0,  1,1,W,1);
        add(0,0,0, 0,0, 0, 0,0, 1,1,  0,1,R,1);
        add(1,1,4, 0,0, 0, 0,0, 0,0,  0,1,R,1);
        add(1,0,0, 0,0, 1, 0,0, 0,0,  0,1,D,1);
        add(0,0,0, 0,0, 0, 0,0, 0,1,  0,1,R,1);
        add(0,0,0, 0,0, 0, 1,4, 0,0,  0,0,R,1);

        // Reset state
        #12;
        chk("rst_state", -1, 4'(state_o), 4'(R));
        chk("rst_busy", -1, 4'(busy), 4'd0);
        chk("rst_err", -1, 4'(wb_err), 4'd0);
        chk("rst_ready", -1, 4'(dec_ready), 4'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge cpu_clk);
            dec_valid = vq[i].dv; read_a = vq[i].ra; arg_a = vq[i].aa;
            read_b = vq[i].ra; arg_b = vq[i].aa;
            wr_en = vq[i].we; wr_reg = vq[i].wr; dec_serial = vq[i].ser;
            wb_en = vq[i].wbe; wb_reg = vq[i].wbr; pc_done = vq[i].pcd; flush = vq[i].fl;
            #1;
            chk("dec_ready", i, 4'(dec_ready), 4'(vq[i].e_rdy));
            @(posedge cpu_clk);
            #1;
            chk("busy", i, 4'(busy), 4'(vq[i].e_busy));
            chk("state", i, 4'(state_o), 4'(vq[i].e_st));
            chk("wb_err", i, 4'(wb_err), 4'(vq[i].e_err));
        end

        // Async reset mid-DRAIN with r1 pending
        @(negedge cpu_clk);
        idle_inputs();
        dec_valid = 1; wr_en = 1; wr_reg = 4'd1;
        @(negedge cpu_clk);
        idle_inputs();
        dec_valid = 1; dec_serial = 1;
        @(negedge cpu_clk);
        idle_inputs();
        chk("pre_rst_state", -2, 4'(state_o), 4'(D));
        chk("pre_rst_busy", -2, 4'(busy), 4'd1);
        #2 cpu_rst = 1'b0;
        #1;
        chk("async_rst_state", -2, 4'(state_o), 4'(R));
        chk("async_rst_busy", -2, 4'(busy), 4'd0);
        chk("async_rst_err", -2, 4'(wb_err), 4'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        dec_valid = 1; read_a = 1; arg_a = 4'd1;
        #1;
        chk("post_rst_ready", -2, 4'(dec_ready), 4'd1);
        @(negedge cpu_clk);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
